// File: rtl/sramlike_arbiter.sv
// ----------------------------------------------------------------------------
// sramlike_arbiter
//
// Purpose:
//   Shares one SRAM-like master port (and therefore one SRAM-like-to-AXI
//   bridge) between the instruction path and the data path. Transactions are
//   serialised: one address handshake, then every data beat of that
//   transaction, then a fresh arbitration on the following cycle.
//
// Handshake semantics (all SRAM-like ports):
//   A request is held with *_req high and stable fields until the cycle in
//   which *_addr_ok is high; that cycle is the address handshake. Each cycle
//   with *_data_ok high delivers one beat (*_rdata valid for reads). Reads
//   deliver burst_len+1 beats, writes exactly one beat.
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   i_*  (in/out)       instruction requester: req/wr/size/addr/wdata/
//                       burst_len in, rdata/addr_ok/data_ok out
//   d_*  (in/out)       data requester, same meaning as i_*
//   m_*  (out/in)       master port towards the bridge
//   dbg_state_o         FSM state for observation: 0 IDLE, 1 ADDR, 2 DATA
//
// Configuration:
//   ARB_RR_EN  when defined, ties are broken by a 1-bit round-robin pointer
//              that flips to the other requester after every completed
//              transaction. When undefined, the data side has fixed priority
//              and the instruction side is forced after STARVE_LIMIT
//              consecutive data grants taken while it was waiting.
// ----------------------------------------------------------------------------
module sramlike_arbiter #(
    parameter int BEAT_CNT_W   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [7:0]  i_burst_len,
    output logic [31:0] i_rdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [7:0]  d_burst_len,
    output logic [31:0] d_rdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [7:0]  m_burst_len,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;   // 1 = data side owns the port
    logic [BEAT_CNT_W-1:0]   beats_q, beats_d;   // beats remaining after the current one

    logic                    gnt;       // IDLE-time winner, 1 = data side
    logic                    sel;       // side currently sourcing m_*
    logic                    sel_wr;
    logic [1:0]              sel_size;
    logic [31:0]             sel_addr;
    logic [31:0]             sel_wdata;
    logic [7:0]              sel_blen;
    logic                    req_int;   // m_req before reset gating
    logic                    hs;        // address handshake this cycle
    logic                    done;      // last beat of the transaction this cycle

`ifdef ARB_RR_EN
    logic rr_q, rr_d;                   // 1 = data side wins the next tie

    always_comb begin
        gnt = (i_req && d_req) ? rr_q : d_req;
    end

    always_comb begin
        rr_d = rr_q;
        if (done) begin
            rr_d = ~owner_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;

    // Data side wins by default; a starved instruction side overrides it.
    always_comb begin
        gnt = (i_req && starve_q == LIMIT) ? 1'b0 : d_req;
    end

    // Counts data grants handed out while the instruction side was waiting.
    always_comb begin
        starve_d = starve_q;
        if (!i_req) begin
            starve_d = '0;
        end else if (hs && !sel) begin
            starve_d = '0;
        end else if (hs && sel && starve_q != LIMIT) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // In IDLE the grant is combinational; afterwards only the registered
    // owner may drive the master port, so the grant cannot move mid-request.
    always_comb begin
        sel = (state_q == IDLE) ? gnt : owner_q;
    end

    always_comb begin
        sel_wr    = sel ? d_wr        : i_wr;
        sel_size  = sel ? d_size      : i_size;
        sel_addr  = sel ? d_addr      : i_addr;
        sel_wdata = sel ? d_wdata     : i_wdata;
        sel_blen  = sel ? d_burst_len : i_burst_len;
    end

    // Next-state logic. m_data_ok outside DATA is a bridge protocol error and
    // is deliberately ignored.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        beats_d = beats_q;
        req_int = 1'b0;
        hs      = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    req_int = 1'b1;
                    owner_d = gnt;
                    if (m_addr_ok) begin
                        hs      = 1'b1;
                        state_d = DATA;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                req_int = 1'b1;
                if (m_addr_ok) begin
                    hs      = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (m_data_ok) begin
                    if (beats_q == '0) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        beats_d = beats_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Writes are single-beat regardless of burst_len.
        if (hs) begin
            beats_d = sel_wr ? '0 : BEAT_CNT_W'(sel_blen);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            beats_q <= beats_d;
        end
    end

    // Every output is forced low while reset is asserted, independent of the
    // inputs, because the bridge is held in reset by the same signal.
    always_comb begin
        m_req       = 1'b0;
        m_wr        = 1'b0;
        m_size      = '0;
        m_addr      = '0;
        m_wdata     = '0;
        m_burst_len = '0;
        i_addr_ok   = 1'b0;
        d_addr_ok   = 1'b0;
        i_data_ok   = 1'b0;
        d_data_ok   = 1'b0;
        i_rdata     = '0;
        d_rdata     = '0;
        dbg_state_o = 2'd0;
        if (resetn) begin
            m_req       = req_int;
            m_wr        = sel_wr;
            m_size      = sel_size;
            m_addr      = sel_addr;
            m_wdata     = sel_wdata;
            m_burst_len = sel_blen;
            i_addr_ok   = hs && !sel;
            d_addr_ok   = hs && sel;
            i_data_ok   = (state_q == DATA) && m_data_ok && !owner_q;
            d_data_ok   = (state_q == DATA) && m_data_ok && owner_q;
            i_rdata     = m_rdata;
            d_rdata     = m_rdata;
            dbg_state_o = state_q;
        end
    end

endmodule

// File: tb/tb_sramlike_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sramlike_arbiter
//
// Drives both requesters and plays the bridge. Expected grants come from a
// transaction-level model of the arbitration rules (pending flags, a starve
// count, a round-robin pointer); expected beats come from the bridge side.
// ----------------------------------------------------------------------------
module tb_sramlike_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    typedef struct {
        bit          valid;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  blen;
    } req_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        resetn;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [7:0]  i_burst_len, d_burst_len;
    logic [31:0] i_rdata, d_rdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [7:0]  m_burst_len;
    logic        m_addr_ok, m_data_ok;
    logic [1:0]  dbg_state_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sramlike_arbiter #(
        .BEAT_CNT_W   (8),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_req       (i_req),
        .i_wr        (i_wr),
        .i_size      (i_size),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_burst_len (i_burst_len),
        .i_rdata     (i_rdata),
        .i_addr_ok   (i_addr_ok),
        .i_data_ok   (i_data_ok),
        .d_req       (d_req),
        .d_wr        (d_wr),
        .d_size      (d_size),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_burst_len (d_burst_len),
        .d_rdata     (d_rdata),
        .d_addr_ok   (d_addr_ok),
        .d_data_ok   (d_data_ok),
        .m_req       (m_req),
        .m_wr        (m_wr),
        .m_size      (m_size),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_burst_len (m_burst_len),
        .m_rdata     (m_rdata),
        .m_addr_ok   (m_addr_ok),
        .m_data_ok   (m_data_ok),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- model and scoreboard state ----------------
    req_t        ireq, dreq;
    int          m_starve;
    bit          m_rr;          // 1 = data side wins the next tie
    bit          i_greedy, d_greedy, rand_arrivals;
    logic [31:0] exp_q[$];
    int          n_tests;
    int          n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic req_t new_req();
        req_t r;
        r.valid = 1'b1;
        r.wr    = ($urandom_range(0, 3) == 0);
        r.size  = 2'($urandom_range(0, 3));
        r.addr  = $urandom;
        r.wdata = $urandom;
        r.blen  = 8'($urandom_range(0, 7));
        return r;
    endfunction

    function automatic bit model_grant_d();
`ifdef ARB_RR_EN
        if (ireq.valid && dreq.valid) return m_rr;
        return dreq.valid;
`else
        if (ireq.valid && m_starve == STARVE_LIMIT) return 1'b0;
        return dreq.valid;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive();
        i_req = ireq.valid; i_wr = ireq.wr; i_size = ireq.size;
        i_addr = ireq.addr; i_wdata = ireq.wdata; i_burst_len = ireq.blen;
        d_req = dreq.valid; d_wr = dreq.wr; d_size = dreq.size;
        d_addr = dreq.addr; d_wdata = dreq.wdata; d_burst_len = dreq.blen;
    endtask

    // Close the current cycle: apply the starvation rule to what was driven
    // during it, then move to just after the next rising edge.
    task automatic adv(input bit hs, input bit hs_d);
        if (!ireq.valid) m_starve = 0;
        else if (hs && !hs_d) m_starve = 0;
        else if (hs && hs_d && m_starve < STARVE_LIMIT) m_starve++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_rst_zero(input string tag);
        check_eq({tag, "_ctrl"}, {14'd0, m_req, m_wr, m_size, i_addr_ok, d_addr_ok,
                                  i_data_ok, d_data_ok, dbg_state_o, m_burst_len}, 32'd0);
        check_eq({tag, "_m_addr"}, m_addr, 32'd0);
        check_eq({tag, "_m_wdata"}, m_wdata, 32'd0);
        check_eq({tag, "_i_rdata"}, i_rdata, 32'd0);
        check_eq({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    task automatic spurious_idle(input string tag);
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        m_rdata   = $urandom;
        drive();
        #1;
        check_eq({tag, "_i_data_ok"}, i_data_ok, 1'b0);
        check_eq({tag, "_d_data_ok"}, d_data_ok, 1'b0);
        check_eq({tag, "_m_req"}, m_req, 1'b0);
        adv(1'b0, 1'b0);
        check_eq({tag, "_state"}, dbg_state_o, ST_IDLE);
        m_data_ok = 1'b0;
    endtask

    // Reset asserted in the middle of a transaction; both requesters abandon.
    task automatic reset_mid();
        resetn    = 1'b0;
        m_addr_ok = 1'b1;
        m_data_ok = 1'b1;
        m_rdata   = $urandom;
        drive();
        #1;
        check_rst_zero("rst_mid");
        @(posedge clk);
        #1;
        check_rst_zero("rst_hold");
        ireq.valid = 1'b0;
        dreq.valid = 1'b0;
        m_starve   = 0;
        m_rr       = 1'b0;
        exp_q.delete();
        drive();
        resetn = 1'b1;
        spurious_idle("post_rst");
    endtask

    task automatic run_round(input int delay_in, input bit raise_other,
                             input int abort_after, output bit got_d);
        bit          exp_d;
        req_t        w;
        int          delay, beats, gaps, seen;
        logic [31:0] rd;
        exp_d = model_grant_d();
        w     = exp_d ? dreq : ireq;
        delay = (delay_in < 0) ? $urandom_range(0, 3) : delay_in;
        got_d = 1'b0;
        // Address phase; the loser may raise its request once the grant is locked.
        for (int c = 0; c <= delay; c++) begin
            if (c >= 1 && (raise_other || (rand_arrivals && $urandom_range(0, 3) == 0))) begin
                if (exp_d && !ireq.valid) ireq = new_req();
                if (!exp_d && !dreq.valid) dreq = new_req();
            end
            m_addr_ok = (c == delay);
            m_data_ok = 1'($urandom_range(0, 1));
            m_rdata   = $urandom;
            drive();
            #1;
            check_eq("addr_state", dbg_state_o, (c == 0) ? ST_IDLE : ST_ADDR);
            check_eq("m_req", m_req, 1'b1);
            check_eq("m_wr", m_wr, w.wr);
            check_eq("m_size", m_size, w.size);
            check_eq("m_addr", m_addr, w.addr);
            check_eq("m_wdata", m_wdata, w.wdata);
            check_eq("m_burst_len", m_burst_len, w.blen);
            check_eq("i_addr_ok", i_addr_ok, (c == delay) && !exp_d);
            check_eq("d_addr_ok", d_addr_ok, (c == delay) && exp_d);
            check_eq("addr_i_data_ok", i_data_ok, 1'b0);
            check_eq("addr_d_data_ok", d_data_ok, 1'b0);
            if (c == delay) got_d = d_addr_ok;
            adv(c == delay, exp_d);
        end
        if (exp_d) dreq.valid = 1'b0;
        else ireq.valid = 1'b0;
        m_addr_ok = 1'b0;
        // Data phase, bridge inserts random gaps between beats.
        beats = w.wr ? 1 : int'(w.blen) + 1;
        seen  = 0;
        for (int b = 0; b < beats; b++) begin
            if (b == abort_after) begin
                reset_mid();
                return;
            end
            gaps = $urandom_range(0, 2);
            for (int g = 0; g <= gaps; g++) begin
                if (b == 0 && g == 0 && exp_d && d_greedy) dreq = new_req();
                if (b == 0 && g == 0 && !exp_d && i_greedy) ireq = new_req();
                if (rand_arrivals) begin
                    if (!ireq.valid && $urandom_range(0, 3) == 0) ireq = new_req();
                    if (!dreq.valid && $urandom_range(0, 3) == 0) dreq = new_req();
                end
                rd        = $urandom;
                m_rdata   = rd;
                m_data_ok = (g == gaps);
                if (g == gaps) exp_q.push_back(rd);
                drive();
                #1;
                check_eq("data_state", dbg_state_o, ST_DATA);
                check_eq("data_m_req", m_req, 1'b0);
                check_eq("data_i_addr_ok", i_addr_ok, 1'b0);
                check_eq("data_d_addr_ok", d_addr_ok, 1'b0);
                check_eq("i_data_ok", i_data_ok, (g == gaps) && !exp_d);
                check_eq("d_data_ok", d_data_ok, (g == gaps) && exp_d);
                check_eq("i_rdata", i_rdata, rd);
                check_eq("d_rdata", d_rdata, rd);
                if ((exp_d ? d_data_ok : i_data_ok) && exp_q.size() > 0) begin
                    check_eq("beat_rdata", exp_d ? d_rdata : i_rdata, exp_q.pop_front());
                    seen++;
                end
                adv(1'b0, 1'b0);
            end
        end
        m_data_ok = 1'b0;
        check_eq("beat_count", seen, beats);
        exp_q.delete();
        m_rr = !exp_d;
    endtask

    task automatic drain();
        bit g;
        for (int k = 0; k < 8 && (ireq.valid || dreq.valid); k++) run_round(-1, 1'b0, -1, g);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit         g;
        logic [4:0] pat;
        n_tests = 0;
        n_fail  = 0;
        m_starve = 0;
        m_rr = 1'b0;
        i_greedy = 1'b0;
        d_greedy = 1'b0;
        rand_arrivals = 1'b0;
        pat = '0;

        // Reset with busy inputs: every output must still be 0.
        resetn    = 1'b0;
        ireq      = new_req();
        dreq      = new_req();
        m_addr_ok = 1'b1;
        m_data_ok = 1'b1;
        m_rdata   = $urandom;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check_rst_zero("rst0");
        ireq.valid = 1'b0;
        dreq.valid = 1'b0;
        m_addr_ok  = 1'b0;
        m_data_ok  = 1'b0;
        drive();
        resetn = 1'b1;
        adv(1'b0, 1'b0);
        check_eq("rst0_state", dbg_state_o, ST_IDLE);

        // Instruction read of 8 beats, address accepted immediately.
        ireq = new_req(); ireq.wr = 1'b0; ireq.blen = 8'd7;
        run_round(0, 1'b0, -1, g);
        check_eq("t1_grant_i", g, 1'b0);

        // Tie with a data write of burst_len 7: data first, one beat, then inst.
        ireq = new_req(); ireq.wr = 1'b0;
        dreq = new_req(); dreq.wr = 1'b1; dreq.blen = 8'd7;
        run_round(-1, 1'b0, -1, g);
        check_eq("t2_grant_d", g, 1'b1);
        run_round(-1, 1'b0, -1, g);
        check_eq("t2_then_i", g, 1'b0);

        // Both sides keep requesting: starvation limit / alternation.
        ireq = new_req();
        dreq = new_req();
        i_greedy = 1'b1;
        d_greedy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run_round(-1, 1'b0, -1, g);
            pat[k] = g;
        end
        i_greedy = 1'b0;
        d_greedy = 1'b0;
`ifdef ARB_RR_EN
        check_eq("rr_alternate", pat[3:0] ^ pat[4:1], 4'hf);
`else
        check_eq("starve_seq", pat, 5'b01111);
`endif
        drain();

        // Delayed addr_ok on an inst grant while data raises its request.
        ireq = new_req();
        run_round(3, 1'b1, -1, g);
        check_eq("t4_grant_i", g, 1'b0);
        drain();

        // Reset with 3 beats left of an 8-beat read.
        ireq = new_req(); ireq.wr = 1'b0; ireq.blen = 8'd7;
        run_round(0, 1'b0, 5, g);

        // Spurious data_ok around a single-beat data read.
        spurious_idle("spur_a");
        dreq = new_req(); dreq.wr = 1'b0; dreq.blen = 8'd0;
        run_round(-1, 1'b0, -1, g);
        check_eq("t6_grant_d", g, 1'b1);
        spurious_idle("spur_b");

        // Longest burst: 256 beats.
        dreq = new_req(); dreq.wr = 1'b0; dreq.blen = 8'd255;
        run_round(0, 1'b0, -1, g);

        // Randomised traffic against the model.
        rand_arrivals = 1'b1;
        for (int r = 0; r < 150; r++) begin
            i_greedy = ($urandom_range(0, 3) == 0);
            d_greedy = ($urandom_range(0, 1) == 0);
            if (!ireq.valid && !dreq.valid) begin
                case ($urandom_range(0, 2))
                    0: ireq = new_req();
                    1: dreq = new_req();
                    default: begin
                        ireq = new_req();
                        dreq = new_req();
                    end
                endcase
            end
            run_round(-1, 1'b0, -1, g);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
